shiftreg_seq_ctrl: RTL

- Sequencer for a WIDTH-bit parallel-load / shift-right register built from mux+DFF bit cells.
- Each cell's controls are load L, shift-enable E, parallel input r_in, and serial fill into the MSB.
- Accepts a start request with a parallel word, drives one load strobe, then exactly WIDTH shift strobes, then pulses done.
- Sits between a requesting controller and the shift-register datapath. The register itself is external.

---
 rtl/shiftreg_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/shiftreg_seq_ctrl.sv
// shiftreg_seq_ctrl: load-then-shift sequencer for a mux+DFF shift register.
// Optional abort path is compiled in when SEQ_ABORT_EN is defined.
module shiftreg_seq_ctrl #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fill_in,
  input  logic             hold,
`ifdef SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             ld,
  output logic             shift_ena,
  output logic [WIDTH-1:0] r_out,
  output logic             w_out,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_n;
  logic             busy_n;
  logic             ld_n;
  logic             se_n;
  logic             done_n;
  logic             w_n;
  logic [WIDTH-1:0] r_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
`ifdef SEQ_ABORT_EN
  logic             aborted_n;
`endif

  // count the strobe currently on the bus as completed at this edge
  assign cnt_inc = bit_cnt + {{(CNT_W-1){1'b0}}, shift_ena};

  // next state and next registered outputs
  always_comb begin
    state_n = state;
    busy_n  = 1'b0;
    ld_n    = 1'b0;
    se_n    = 1'b0;
    done_n  = 1'b0;
    r_n     = r_out;
    w_n     = w_out;
    cnt_n   = bit_cnt;
`ifdef SEQ_ABORT_EN
    aborted_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          r_n     = data_in;
          w_n     = fill_in;
          cnt_n   = '0;
          busy_n  = 1'b1;
          ld_n    = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        busy_n  = 1'b1;
        se_n    = ~hold;
        state_n = SHIFT;
      end
      SHIFT: begin
        busy_n = 1'b1;
        cnt_n  = cnt_inc;
        if (cnt_inc == LAST) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          se_n = ~hold;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
`ifdef SEQ_ABORT_EN
    if (abort && (state == LOAD || state == SHIFT)) begin
      state_n   = IDLE;
      busy_n    = 1'b0;
      ld_n      = 1'b0;
      se_n      = 1'b0;
      done_n    = 1'b0;
      cnt_n     = bit_cnt;
      aborted_n = 1'b1;
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ld        <= 1'b0;
      shift_ena <= 1'b0;
      done      <= 1'b0;
      r_out     <= '0;
      w_out     <= 1'b0;
      bit_cnt   <= '0;
`ifdef SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      ld        <= ld_n;
      shift_ena <= se_n;
      done      <= done_n;
      r_out     <= r_n;
      w_out     <= w_n;
      bit_cnt   <= cnt_n;
`ifdef SEQ_ABORT_EN
      aborted   <= aborted_n;
`endif
    end
  end

endmodule
